// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: steps fetch, execute, memory and writeback
// phases and drives the datapath enables from the registered state.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  IDLE       | parked, waiting for run
//  FETCH      | PC presented to instruction memory
//  FETCH_WAIT | waiting IMEM_LATENCY cycles, ir_load on the last one
//  EXECUTE    | decode/ALU, choose MEM or WRITEBACK
//  MEM        | load (DMEM_LATENCY cycles of dmem_re) or store (1 cycle)
//  WRITEBACK  | register write, PC update, retire
module core_sequencer #(
   parameter int unsigned IMEM_LATENCY = 1,
   parameter int unsigned DMEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        reg_write,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        branch_taken,
   output logic        ir_load,
   output logic        pc_en,
   output logic        pc_sel,
   output logic        regfile_we,
   output logic        dmem_re,
   output logic        dmem_we,
   output logic        busy,
   output logic [2:0]  state,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_FETCH      = 3'd1,
      S_FETCH_WAIT = 3'd2,
      S_EXECUTE    = 3'd3,
      S_MEM        = 3'd4,
      S_WRITEBACK  = 3'd5
   } state_t;

   // Counter counts down to zero, so it is loaded with latency-1.
   localparam logic [2:0] IMEM_RELOAD = 3'(IMEM_LATENCY - 1);
   localparam logic [2:0] DMEM_RELOAD = 3'(DMEM_LATENCY - 1);

   state_t      state_q, state_d;
   logic [2:0]  lat_cnt_q, lat_cnt_d;
   logic [31:0] retired_q, retired_d;
   logic        is_load_q, is_load_d;

   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      retired_d = retired_q;
      is_load_d = is_load_q;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d   = S_FETCH_WAIT;
            lat_cnt_d = IMEM_RELOAD;
         end
         S_FETCH_WAIT: begin
            if (lat_cnt_q == 3'd0) state_d = S_EXECUTE;
            else                   lat_cnt_d = lat_cnt_q - 3'd1;
         end
         S_EXECUTE: begin
            // Load wins when both are requested, so a conflict never writes memory.
            is_load_d = mem_read;
            if (mem_read || mem_write) begin
               state_d   = S_MEM;
               lat_cnt_d = mem_read ? DMEM_RELOAD : 3'd0;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_MEM: begin
            if (lat_cnt_q == 3'd0) state_d = S_WRITEBACK;
            else                   lat_cnt_d = lat_cnt_q - 3'd1;
         end
         S_WRITEBACK: begin
            retired_d = retired_q + 32'd1;
            state_d   = run ? S_FETCH : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         lat_cnt_q <= 3'd0;
         retired_q <= 32'd0;
         is_load_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         retired_q <= retired_d;
         is_load_q <= is_load_d;
      end
   end

   // Enables decode only the registered state and the decoder controls;
   // run only steers the next-state logic.
   assign ir_load    = (state_q == S_FETCH_WAIT) && (lat_cnt_q == 3'd0);
   assign dmem_re    = (state_q == S_MEM) &&  is_load_q;
   assign dmem_we    = (state_q == S_MEM) && !is_load_q;
   assign pc_en      = (state_q == S_WRITEBACK);
   assign pc_sel     = (state_q == S_WRITEBACK) && branch_taken;
   assign regfile_we = (state_q == S_WRITEBACK) && reg_write;
   assign busy       = (state_q != S_IDLE);
   assign state      = state_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: cycle-by-cycle vector table on a
// DMEM_LATENCY=3 instance plus latency and corner sequences on an IMEM_LATENCY=3 one.
module tb_core_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic run = 1'b0, rw = 1'b0, mr = 1'b0, mw = 1'b0, bt = 1'b0;

   logic ir_a, pe_a, ps_a, we_a, re_a, dwe_a, busy_a;
   logic [2:0]  st_a;
   logic [31:0] ret_a;
   logic ir_b, pe_b, ps_b, we_b, re_b, dwe_b, busy_b;
   logic [2:0]  st_b;
   logic [31:0] ret_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   core_sequencer #(.IMEM_LATENCY(1), .DMEM_LATENCY(3)) u_a (
      .clk(clk), .rst_n(rst_n), .run(run), .reg_write(rw), .mem_read(mr),
      .mem_write(mw), .branch_taken(bt), .ir_load(ir_a), .pc_en(pe_a),
      .pc_sel(ps_a), .regfile_we(we_a), .dmem_re(re_a), .dmem_we(dwe_a),
      .busy(busy_a), .state(st_a), .retired(ret_a));

   core_sequencer #(.IMEM_LATENCY(3), .DMEM_LATENCY(1)) u_b (
      .clk(clk), .rst_n(rst_n), .run(run), .reg_write(rw), .mem_read(mr),
      .mem_write(mw), .branch_taken(bt), .ir_load(ir_b), .pc_en(pe_b),
      .pc_sel(ps_b), .regfile_we(we_b), .dmem_re(re_b), .dmem_we(dwe_b),
      .busy(busy_b), .state(st_b), .retired(ret_b));

   // in = {run, reg_write, mem_read, mem_write, branch_taken}
   // o  = {ir_load, pc_en, pc_sel, regfile_we, dmem_re, dmem_we}
   typedef struct packed {
      logic [4:0] in;
      logic [2:0] st;
      logic [5:0] o;
   } vec_t;

   vec_t tbl [30];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_a(input logic [2:0] s, input string name);
      int n = 0;
      while (st_a !== s && n < 60) begin
         tick();
         n++;
      end
      check(name, st_a, s);
   endtask

   task automatic wait_b(input logic [2:0] s, input string name);
      int n = 0;
      while (st_b !== s && n < 60) begin
         tick();
         n++;
      end
      check(name, st_b, s);
   endtask

   task automatic do_reset();
      {run, rw, mr, mw, bt} = 5'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Starts at a sample point where u_b is in FETCH; runs one instruction.
   task automatic measure_b(input logic r_w, input logic m_r, input logic m_w,
                            input int exp_len, input int exp_re, input int exp_we,
                            input string name);
      int n = 0, irc = 0, rec = 0, wec = 0;
      rw = r_w; mr = m_r; mw = m_w; bt = 1'b0;
      do begin
         irc += int'(ir_b);
         rec += int'(re_b);
         wec += int'(dwe_b);
         tick();
         n++;
      end while (st_b !== 3'd1 && n < 20);
      check({name, "_len"}, n, exp_len);
      check({name, "_irload"}, irc, 1);
      check({name, "_dmem_re"}, rec, exp_re);
      check({name, "_dmem_we"}, wec, exp_we);
   endtask

   initial begin
      tbl[0]  = '{5'b11000, 3'd0, 6'b000000};
      tbl[1]  = '{5'b11000, 3'd1, 6'b000000};
      tbl[2]  = '{5'b11000, 3'd2, 6'b100000};
      tbl[3]  = '{5'b11000, 3'd3, 6'b000000};
      tbl[4]  = '{5'b11000, 3'd5, 6'b010100};
      tbl[5]  = '{5'b11100, 3'd1, 6'b000000};
      tbl[6]  = '{5'b11100, 3'd2, 6'b100000};
      tbl[7]  = '{5'b11100, 3'd3, 6'b000000};
      tbl[8]  = '{5'b11100, 3'd4, 6'b000010};
      tbl[9]  = '{5'b11100, 3'd4, 6'b000010};
      tbl[10] = '{5'b11100, 3'd4, 6'b000010};
      tbl[11] = '{5'b11100, 3'd5, 6'b010100};
      tbl[12] = '{5'b10010, 3'd1, 6'b000000};
      tbl[13] = '{5'b10010, 3'd2, 6'b100000};
      tbl[14] = '{5'b10010, 3'd3, 6'b000000};
      tbl[15] = '{5'b10010, 3'd4, 6'b000001};
      tbl[16] = '{5'b10010, 3'd5, 6'b010000};
      tbl[17] = '{5'b10110, 3'd1, 6'b000000};
      tbl[18] = '{5'b10110, 3'd2, 6'b100000};
      tbl[19] = '{5'b10110, 3'd3, 6'b000000};
      tbl[20] = '{5'b10110, 3'd4, 6'b000010};
      tbl[21] = '{5'b10110, 3'd4, 6'b000010};
      tbl[22] = '{5'b10110, 3'd4, 6'b000010};
      tbl[23] = '{5'b10110, 3'd5, 6'b010000};
      tbl[24] = '{5'b10001, 3'd1, 6'b000000};
      tbl[25] = '{5'b10001, 3'd2, 6'b100000};
      tbl[26] = '{5'b00001, 3'd3, 6'b000000};
      tbl[27] = '{5'b00001, 3'd5, 6'b011000};
      tbl[28] = '{5'b00000, 3'd0, 6'b000000};
      tbl[29] = '{5'b00000, 3'd0, 6'b000000};

      // Reset values while rst_n is held low.
      repeat (3) tick();
      check("rst_state_a", st_a, 3'd0);
      check("rst_outs_a", {busy_a, ir_a, pe_a, ps_a, we_a, re_a, dwe_a}, 7'd0);
      check("rst_retired_a", ret_a, 32'd0);
      check("rst_state_b", st_b, 3'd0);
      rst_n = 1'b1;

      // Vector table: ALU, load, store, load/store conflict, branch with run drop.
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         {run, rw, mr, mw, bt} = tbl[i].in;
         #1;
         check($sformatf("vec%0d", i),
               {st_a, ir_a, pe_a, ps_a, we_a, re_a, dwe_a, busy_a},
               {tbl[i].st, tbl[i].o, (tbl[i].st != 3'd0)});
      end
      check("table_retired", ret_a, 32'd5);

      // Continuous ALU stream: 3 instructions in 12 cycles from the first FETCH.
      do_reset();
      begin
         logic [2:0] pat [4];
         int wec = 0, pec = 0, psc = 0, irc = 0;
         logic [31:0] base;
         pat[0] = 3'd1; pat[1] = 3'd2; pat[2] = 3'd3; pat[3] = 3'd5;
         run = 1'b1; rw = 1'b1;
         wait_a(3'd1, "alu_first_fetch");
         base = ret_a;
         for (int i = 0; i < 12; i++) begin
            check($sformatf("alu_seq%0d", i), st_a, pat[i % 4]);
            wec += int'(we_a);
            pec += int'(pe_a);
            psc += int'(ps_a);
            irc += int'(ir_a);
            tick();
         end
         check("alu_retired_delta", ret_a - base, 32'd3);
         check("alu_regfile_we_pulses", wec, 3);
         check("alu_pc_en_pulses", pec, 3);
         check("alu_pc_sel_pulses", psc, 0);
         check("alu_ir_load_pulses", irc, 3);
      end

      // Latency per instruction class on the IMEM_LATENCY=3, DMEM_LATENCY=1 instance.
      do_reset();
      run = 1'b1; rw = 1'b1;
      wait_b(3'd1, "b_first_fetch");
      measure_b(1'b1, 1'b0, 1'b0, 6, 0, 0, "b_alu");
      measure_b(1'b1, 1'b1, 1'b0, 7, 1, 0, "b_load");
      measure_b(1'b0, 1'b0, 1'b1, 7, 0, 1, "b_store");
      measure_b(1'b0, 1'b1, 1'b1, 7, 1, 0, "b_conflict");
      run = 1'b0; mr = 1'b0; mw = 1'b0;
      wait_b(3'd0, "b_back_to_idle");
      check("b_retired", ret_b, 32'd5);
      check("b_busy_idle", busy_b, 1'b0);

      // Retired counter wrap.
      do_reset();
      force u_a.retired_q = 32'hFFFF_FFFF;
      #1;
      release u_a.retired_q;
      check("wrap_preload", ret_a, 32'hFFFF_FFFF);
      run = 1'b1; rw = 1'b1;
      tick();
      run = 1'b0;
      check("wrap_fetch", st_a, 3'd1);
      wait_a(3'd0, "wrap_idle");
      check("wrap_retired", ret_a, 32'd0);

      // Asynchronous reset in the middle of a store's MEM cycle.
      do_reset();
      run = 1'b1; rw = 1'b1;
      wait_a(3'd5, "mrst_first_wb");
      tick();
      rw = 1'b0; mw = 1'b1;
      wait_a(3'd4, "mrst_in_mem");
      check("mrst_pre_dmem_we", dwe_a, 1'b1);
      check("mrst_pre_retired", ret_a, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("mrst_async_state", st_a, 3'd0);
      check("mrst_async_retired", ret_a, 32'd0);
      check("mrst_async_outs", {busy_a, dwe_a, re_a, we_a, pe_a}, 5'd0);
      {run, rw, mr, mw, bt} = 5'b0;
      #1;
      rst_n = 1'b1;
      begin
         int bad = 0;
         for (int i = 0; i < 8; i++) begin
            tick();
            if (dwe_a || we_a || pe_a || st_a != 3'd0) bad++;
         end
         check("mrst_no_pulses_after", bad, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
